// File: rtl/lr35902_oam_pkg.sv
// Shared types and constants for the LR35902 OAM controller.
// Build option LR35902_OAM_DMA_ECHO_EN (see lr35902_oam_dma) folds echo-RAM DMA source pages.
package lr35902_oam_pkg;

    localparam int unsigned OAM_BYTES      = 160;
    localparam logic [7:0]  FF46_RST_VAL   = 8'hFF;
    localparam logic [7:0]  BLOCKED_RD_VAL = 8'hFF;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_START = 3'd1,
        DMA_READ  = 3'd2,
        DMA_WRITE = 3'd3,
        DMA_HOLD  = 3'd4
    } dma_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_PPU  = 2'd2,
        OWN_DMA  = 2'd3
    } owner_e;

endpackage

// File: rtl/lr35902_oam_ctrl_if.sv
// Bus bundle between the CPU decoder, PPU, DMA source, OAM RAM and the OAM controller.
interface lr35902_oam_ctrl_if;

    logic [7:0]  cpu_adr;
    logic [7:0]  cpu_din;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_dout;
    logic        ppu_lock;
    logic [7:0]  ppu_adr;
    logic        ppu_read;
    logic        reg_write;
    logic [7:0]  reg_din;
    logic [7:0]  reg_dout;
    logic        dma_req;
    logic [15:0] dma_adr;
    logic [7:0]  dma_din;
    logic        dma_ack;
    logic        dma_active;
    logic [7:0]  oam_adr;
    logic [7:0]  oam_din;
    logic        oam_read;
    logic        oam_write;
    logic [7:0]  oam_dout;

    modport slave (
        input  cpu_adr, cpu_din, cpu_read, cpu_write, ppu_lock, ppu_adr, ppu_read,
               reg_write, reg_din, dma_din, dma_ack, oam_dout,
        output cpu_dout, reg_dout, dma_req, dma_adr, dma_active,
               oam_adr, oam_din, oam_read, oam_write
    );

    modport master (
        output cpu_adr, cpu_din, cpu_read, cpu_write, ppu_lock, ppu_adr, ppu_read,
               reg_write, reg_din, dma_din, dma_ack, oam_dout,
        input  cpu_dout, reg_dout, dma_req, dma_adr, dma_active,
               oam_adr, oam_din, oam_read, oam_write
    );

endinterface

// File: rtl/lr35902_oam_dma.sv
// FF46 OAM DMA engine: copies OAM_BYTES bytes from page XX00 into OAM, one READ/WRITE/HOLD per byte.
// Define LR35902_OAM_DMA_ECHO_EN to fold source pages E0-FF onto C0-DF.
module lr35902_oam_dma #(
    parameter int unsigned OAM_BYTES = lr35902_oam_pkg::OAM_BYTES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reg_write,
    input  logic [7:0]  reg_din,
    input  logic        wr_prev,
    input  logic [7:0]  dma_din,
    input  logic        dma_ack,
    output logic [7:0]  reg_dout,
    output logic        dma_req,
    output logic [15:0] dma_adr,
    output logic        dma_active,
    output logic [7:0]  oam_adr,
    output logic [7:0]  oam_din,
    output logic        oam_write
);
    import lr35902_oam_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

    dma_state_e state_q, state_d;
    logic [7:0] index_q, index_d;
    logic [7:0] page_q, page_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] data_q, data_d;
    logic       restart_q, restart_d;
    logic [7:0] src_page;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= DMA_IDLE;
            index_q   <= '0;
            page_q    <= '0;
            pend_q    <= FF46_RST_VAL;
            data_q    <= '0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            page_q    <= page_d;
            pend_q    <= pend_d;
            data_q    <= data_d;
            restart_q <= restart_d;
        end
    end

    // A write while busy only parks the new page; the in-flight byte drains through HOLD first.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        page_d    = page_q;
        pend_d    = pend_q;
        data_d    = data_q;
        restart_d = restart_q;
        if (reg_write) pend_d = reg_din;
        case (state_q)
            DMA_IDLE: begin
                if (reg_write) begin
                    state_d = DMA_START;
                    index_d = '0;
                end
            end
            DMA_START: begin
                if (!reg_write && !wr_prev) begin
                    state_d   = DMA_READ;
                    page_d    = pend_q;
                    restart_d = 1'b0;
                end
            end
            DMA_READ: begin
                if (reg_write) restart_d = 1'b1;
                if (dma_ack) begin
                    state_d = DMA_WRITE;
                    data_d  = dma_din;
                end
            end
            DMA_WRITE: begin
                if (reg_write) restart_d = 1'b1;
                state_d = DMA_HOLD;
            end
            DMA_HOLD: begin
                if (restart_q || reg_write) begin
                    state_d   = DMA_START;
                    index_d   = '0;
                    restart_d = 1'b0;
                end else if (index_q == LAST_IDX) begin
                    state_d = DMA_IDLE;
                end else begin
                    state_d = DMA_READ;
                    index_d = index_q + 8'd1;
                end
            end
            default: state_d = DMA_IDLE;
        endcase
    end

`ifdef LR35902_OAM_DMA_ECHO_EN
    assign src_page = (page_q[7:5] == 3'b111) ? {page_q[7:6], 1'b0, page_q[4:0]} : page_q;
`else
    assign src_page = page_q;
`endif

    assign reg_dout   = pend_q;
    assign dma_active = (state_q != DMA_IDLE);
    assign dma_req    = (state_q == DMA_READ);
    assign dma_adr    = {src_page, index_q};
    assign oam_adr    = index_q;
    assign oam_din    = data_q;
    assign oam_write  = (state_q == DMA_WRITE);

endmodule

// File: rtl/lr35902_oam_ctrl.sv
// OAM access controller: arbitrates DMA > PPU > CPU onto the OAM RAM and blocks CPU accesses.
// Build option LR35902_OAM_DMA_ECHO_EN is handled inside lr35902_oam_dma.
module lr35902_oam_ctrl #(
    parameter int unsigned OAM_BYTES = lr35902_oam_pkg::OAM_BYTES
) (
    input logic               clk,
    input logic               reset_n,
    lr35902_oam_ctrl_if.slave bus
);
    import lr35902_oam_pkg::*;

    logic       dma_active;
    logic       dma_wr;
    logic [7:0] dma_oam_adr;
    logic [7:0] dma_oam_din;
    logic       blocked;
    logic       live_q;
    logic       wr_prev_q;
    logic       blk_rd_q;
    owner_e     grant_q, grant, want;
    logic [7:0] adr_c, din_c;
    logic       rd_c, wr_c;

    lr35902_oam_dma #(.OAM_BYTES(OAM_BYTES)) u_dma (
        .clk        (clk),
        .reset_n    (reset_n),
        .reg_write  (bus.reg_write),
        .reg_din    (bus.reg_din),
        .wr_prev    (wr_prev_q),
        .dma_din    (bus.dma_din),
        .dma_ack    (bus.dma_ack),
        .reg_dout   (bus.reg_dout),
        .dma_req    (bus.dma_req),
        .dma_adr    (bus.dma_adr),
        .dma_active (dma_active),
        .oam_adr    (dma_oam_adr),
        .oam_din    (dma_oam_din),
        .oam_write  (dma_wr)
    );

    assign blocked = dma_active | bus.ppu_lock;

    // Grant may only move once the previous cycle's write strobe has dropped.
    always_comb begin
        want  = OWN_CPU;
        adr_c = '0;
        din_c = '0;
        rd_c  = 1'b0;
        wr_c  = 1'b0;
        if (dma_active)        want = OWN_DMA;
        else if (bus.ppu_lock) want = OWN_PPU;
        grant = wr_prev_q ? grant_q : want;
        if (!live_q) grant = OWN_NONE;
        case (grant)
            OWN_CPU: begin
                adr_c = bus.cpu_adr;
                din_c = bus.cpu_din;
                rd_c  = bus.cpu_read & ~blocked;
                wr_c  = bus.cpu_write & ~blocked;
            end
            OWN_PPU: begin
                adr_c = bus.ppu_adr;
                rd_c  = bus.ppu_read;
            end
            OWN_DMA: begin
                adr_c = dma_oam_adr;
                din_c = dma_oam_din;
                wr_c  = dma_wr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live_q    <= 1'b0;
            grant_q   <= OWN_NONE;
            wr_prev_q <= 1'b0;
            blk_rd_q  <= 1'b1;
        end else begin
            live_q    <= 1'b1;
            grant_q   <= grant;
            wr_prev_q <= wr_c;
            blk_rd_q  <= bus.cpu_read & blocked;
        end
    end

    assign bus.dma_active = dma_active;
    assign bus.oam_adr    = adr_c;
    assign bus.oam_din    = din_c;
    assign bus.oam_read   = rd_c;
    assign bus.oam_write  = wr_c;
    assign bus.cpu_dout   = blk_rd_q ? BLOCKED_RD_VAL : bus.oam_dout;

endmodule
